stage_ex_md: RTL and testbench

Parametrised execute stage: 2-bit forwarding muxes for both operands, A/B source selects (PC / immediate), and the existing single-cycle ALU. Adds an iterative unsigned multiply/divide unit that holds the pipeline with a stall while it runs. Sits between the ID/EX and EX/MEM pipeline registers. The hazard unit ORs `ex_stall` into its global stall.

---
 rtl/stage_ex_md_pkg.sv | 41 ++++
 rtl/stage_ex_md_if.sv | 40 ++++
 rtl/stage_ex_md_alu.sv | 27 ++
 rtl/stage_ex_md_muldiv_iter.sv | 114 +++++++++++
 rtl/stage_ex_md.sv | 64 ++++++
 tb/tb_stage_ex_md.sv | 294 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/stage_ex_md_pkg.sv
// Shared encodings for the execute stage: forward selects, ALU selects, mul/div ops and FSM states.
package stage_ex_md_pkg;

    localparam int unsigned REG_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        FWD_IDEX = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLL  = 3'd5,
        ALU_SRL  = 3'd6,
        ALU_SLTU = 3'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Divide-class ops share the quotient/remainder datapath.
    function automatic logic is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/stage_ex_md_if.sv
// ID/EX-side bundle into the execute stage and its results back out.
interface stage_ex_md_if #(
    parameter int unsigned REG_WIDTH = stage_ex_md_pkg::REG_WIDTH_DEF
);
    logic                 ID_EX_valid;
    logic                 flush;
    logic [1:0]           forwardA;
    logic [1:0]           forwardB;
    logic [REG_WIDTH-1:0] ID_EX_data_out_1;
    logic [REG_WIDTH-1:0] ID_EX_data_out_2;
    logic [REG_WIDTH-1:0] ID_EX_imm_out;
    logic [REG_WIDTH-1:0] ID_EX_pc;
    logic [REG_WIDTH-1:0] WB_data;
    logic [REG_WIDTH-1:0] EX_MEM_alu_out;
    logic [2:0]           ID_EX_alu_sel;
    logic                 ID_EX_ASel;
    logic                 ID_EX_BSel;
    logic                 ID_EX_md_en;
    logic [1:0]           ID_EX_md_op;
    logic [REG_WIDTH-1:0] alu_out;
    logic [REG_WIDTH-1:0] dataB;
    logic                 ex_stall;
    logic                 md_done;

    modport master (
        output ID_EX_valid, flush, forwardA, forwardB,
               ID_EX_data_out_1, ID_EX_data_out_2, ID_EX_imm_out, ID_EX_pc,
               WB_data, EX_MEM_alu_out, ID_EX_alu_sel, ID_EX_ASel, ID_EX_BSel,
               ID_EX_md_en, ID_EX_md_op,
        input  alu_out, dataB, ex_stall, md_done
    );

    modport slave (
        input  ID_EX_valid, flush, forwardA, forwardB,
               ID_EX_data_out_1, ID_EX_data_out_2, ID_EX_imm_out, ID_EX_pc,
               WB_data, EX_MEM_alu_out, ID_EX_alu_sel, ID_EX_ASel, ID_EX_BSel,
               ID_EX_md_en, ID_EX_md_op,
        output alu_out, dataB, ex_stall, md_done
    );
endinterface

// File: rtl/stage_ex_md_alu.sv
// Single-cycle integer ALU shared with the decoder's select encoding.
module alu
    import stage_ex_md_pkg::*;
#(
    parameter int unsigned W = REG_WIDTH_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   sel,
    output logic [W-1:0] y
);
    localparam int unsigned SH_W = $clog2(W);

    always_comb begin
        y = '0;
        case (sel)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[SH_W-1:0];
            ALU_SRL:  y = a >> b[SH_W-1:0];
            default:  y = {{(W-1){1'b0}}, (a < b)};
        endcase
    end
endmodule

// File: rtl/stage_ex_md_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
module muldiv_iter
    import stage_ex_md_pkg::*;
#(
    parameter int unsigned W = REG_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  md_op_e       op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int unsigned CNT_W = $clog2(W + 1);

    md_state_e        state;
    md_state_e        state_nxt;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    md_op_e           op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     quo;
    logic [W-1:0]     rem;
    logic [2*W-1:0]   prod;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_trial;
    logic             div_fits;

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    // Stall is asserted combinationally in the accept cycle so ID/EX holds.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && !flush && !reset) begin
                    accept    = 1'b1;
                    busy      = 1'b1;
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (flush || reset) begin
                    state_nxt = MD_IDLE;
                end else begin
                    busy = 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                done      = !flush && !reset;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // A zero divisor always "fits", yielding all-ones quotient and the dividend as remainder.
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, a_q & {W{prod[0]}}};
        div_shift = {rem, quo[W-1]};
        div_trial = div_shift - {1'b0, b_q};
        div_fits  = ~div_trial[W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= MD_MUL;
            a_q  <= '0;
            b_q  <= '0;
            prod <= '0;
            quo  <= '0;
            rem  <= '0;
        end else if (accept) begin
            cnt  <= CNT_W'(W);
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            prod <= {{W{1'b0}}, b};
            quo  <= a;
            rem  <= '0;
        end else if (state == MD_BUSY && !flush) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div(op_q)) begin
                rem <= div_fits ? div_trial[W-1:0] : div_shift[W-1:0];
                quo <= {quo[W-2:0], div_fits};
            end else begin
                prod <= {mul_sum, prod[W-1:1]};
            end
        end
    end

    always_comb begin
        case (op_q)
            MD_MUL:   result = prod[W-1:0];
            MD_MULHU: result = prod[2*W-1:W];
            MD_DIVU:  result = quo;
            default:  result = rem;
        endcase
    end
endmodule

// File: rtl/stage_ex_md.sv
// Execute stage: operand forwarding, A/B source selects, ALU and stalling mul/div unit.
module stage_ex_md
    import stage_ex_md_pkg::*;
#(
    parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
    parameter int unsigned MD_EN     = 1
) (
    input  logic         clk,
    input  logic         reset,
    stage_ex_md_if.slave ex
);
    logic [REG_WIDTH-1:0] fwd_a;
    logic [REG_WIDTH-1:0] fwd_b;
    logic [REG_WIDTH-1:0] op_a;
    logic [REG_WIDTH-1:0] op_b;
    logic [REG_WIDTH-1:0] alu_res;
    logic [REG_WIDTH-1:0] md_res;
    logic                 md_start;
    logic                 md_busy;
    logic                 md_done;

    // Reserved forward code 11 falls back to the ID/EX value.
    always_comb begin
        case (ex.forwardA)
            FWD_WB:  fwd_a = ex.WB_data;
            FWD_MEM: fwd_a = ex.EX_MEM_alu_out;
            default: fwd_a = ex.ID_EX_data_out_1;
        endcase
        case (ex.forwardB)
            FWD_WB:  fwd_b = ex.WB_data;
            FWD_MEM: fwd_b = ex.EX_MEM_alu_out;
            default: fwd_b = ex.ID_EX_data_out_2;
        endcase
        op_a = ex.ID_EX_ASel ? ex.ID_EX_pc : fwd_a;
        op_b = ex.ID_EX_BSel ? ex.ID_EX_imm_out : fwd_b;
    end

    alu #(.W(REG_WIDTH)) u_alu (
        .a   (op_a),
        .b   (op_b),
        .sel (ex.ID_EX_alu_sel),
        .y   (alu_res)
    );

    assign md_start = (MD_EN != 0) && ex.ID_EX_valid && ex.ID_EX_md_en;

    muldiv_iter #(.W(REG_WIDTH)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (md_op_e'(ex.ID_EX_md_op)),
        .a      (op_a),
        .b      (op_b),
        .flush  (ex.flush),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
    );

    assign ex.alu_out  = md_done ? md_res : alu_res;
    assign ex.dataB    = fwd_b;
    assign ex.ex_stall = md_busy;
    assign ex.md_done  = md_done;
endmodule

// File: tb/tb_stage_ex_md.sv
// Self-checking bench for stage_ex_md: directed and randomized ALU/forwarding and mul/div sequences.
module tb_stage_ex_md;
    import stage_ex_md_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stage_ex_md_if #(.REG_WIDTH(W)) bus ();

    stage_ex_md #(.REG_WIDTH(W), .MD_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fwd_pick(input logic [1:0] f, input logic [W-1:0] idex,
                                              input logic [W-1:0] wb, input logic [W-1:0] mem);
        if (f == 2'b01) return wb;
        if (f == 2'b10) return mem;
        return idex;
    endfunction

    function automatic logic [W-1:0] alu_model(input logic [2:0] sel, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int unsigned sh;
        sh = b % W;
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return a >> sh;
            default: return (a < b) ? W'(1) : W'(0);
        endcase
    endfunction

    function automatic logic [W-1:0] md_model(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'b00: return p[W-1:0];
            2'b01: return p[2*W-1:W];
            2'b10: begin
                if (b == 0) return {W{1'b1}};
                return a / b;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Junk on every data/select input; leaves valid, md_en, md_op and flush alone.
    task automatic randomize_bus();
        bus.forwardA         = 2'($urandom_range(0, 3));
        bus.forwardB         = 2'($urandom_range(0, 3));
        bus.ID_EX_data_out_1 = W'($urandom);
        bus.ID_EX_data_out_2 = W'($urandom);
        bus.ID_EX_imm_out    = W'($urandom);
        bus.ID_EX_pc         = W'($urandom);
        bus.WB_data          = W'($urandom);
        bus.EX_MEM_alu_out   = W'($urandom);
        bus.ID_EX_alu_sel    = 3'($urandom_range(0, 7));
        bus.ID_EX_ASel       = 1'($urandom_range(0, 1));
        bus.ID_EX_BSel       = 1'($urandom_range(0, 1));
    endtask

    // Route operand a via rs1/EX_MEM/PC and operand b via rs2/WB/imm.
    task automatic place_operands(input logic [W-1:0] a, input logic [W-1:0] b);
        randomize_bus();
        case ($urandom_range(0, 3))
            0: begin bus.ID_EX_ASel = 1'b0; bus.forwardA = 2'b00; bus.ID_EX_data_out_1 = a; end
            1: begin bus.ID_EX_ASel = 1'b0; bus.forwardA = 2'b11; bus.ID_EX_data_out_1 = a; end
            2: begin bus.ID_EX_ASel = 1'b0; bus.forwardA = 2'b10; bus.EX_MEM_alu_out = a; end
            default: begin bus.ID_EX_ASel = 1'b1; bus.ID_EX_pc = a; end
        endcase
        case ($urandom_range(0, 3))
            0: begin bus.ID_EX_BSel = 1'b0; bus.forwardB = 2'b00; bus.ID_EX_data_out_2 = b; end
            1: begin bus.ID_EX_BSel = 1'b0; bus.forwardB = 2'b11; bus.ID_EX_data_out_2 = b; end
            2: begin bus.ID_EX_BSel = 1'b0; bus.forwardB = 2'b01; bus.WB_data = b; end
            default: begin bus.ID_EX_BSel = 1'b1; bus.ID_EX_imm_out = b; end
        endcase
    endtask

    task automatic start_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ID_EX_valid = 1'b1;
        bus.ID_EX_md_en = 1'b1;
        bus.ID_EX_md_op = op;
        bus.flush       = 1'b0;
        place_operands(a, b);
    endtask

    // Called just after an edge; returns just after the edge following md_done.
    task automatic run_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] exp;
        int c;
        int stalls;
        exp = md_model(op, a, b);
        start_md(op, a, b);
        settle();
        check({tag, " accept stall"}, 64'(bus.ex_stall), 64'(1));
        check({tag, " no done at accept"}, 64'(bus.md_done), 64'(0));
        c = 0;
        stalls = 0;
        while (!bus.md_done && c < 40) begin
            if (bus.ex_stall) stalls++;
            tick();
            c++;
            if (c == 1) randomize_bus();
        end
        check({tag, " latency"}, 64'(c), 64'(W + 1));
        check({tag, " stall cycles"}, 64'(stalls), 64'(W + 1));
        check({tag, " result"}, 64'(bus.alu_out), 64'(exp));
        check({tag, " stall in done"}, 64'(bus.ex_stall), 64'(0));
        tick();
    endtask

    initial begin
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           dones;

        reset           = 1'b1;
        bus.ID_EX_valid = 1'b0;
        bus.ID_EX_md_en = 1'b0;
        bus.ID_EX_md_op = 2'b00;
        bus.flush       = 1'b0;
        randomize_bus();
        tick();
        tick();

        // Reset wins over a same-cycle accept
        bus.ID_EX_valid = 1'b1;
        bus.ID_EX_md_en = 1'b1;
        settle();
        check("reset blocks accept", 64'(bus.ex_stall), 64'(0));
        tick();
        reset = 1'b0;
        bus.ID_EX_md_en = 1'b0;
        settle();
        check("reset stall", 64'(bus.ex_stall), 64'(0));
        check("reset done", 64'(bus.md_done), 64'(0));

        // Directed forwarding add
        bus.ID_EX_valid    = 1'b1;
        bus.forwardA       = 2'b10;
        bus.EX_MEM_alu_out = W'(5);
        bus.forwardB       = 2'b01;
        bus.WB_data        = W'(7);
        bus.ID_EX_ASel     = 1'b0;
        bus.ID_EX_BSel     = 1'b0;
        bus.ID_EX_alu_sel  = ALU_ADD;
        settle();
        check("fwd add alu_out", 64'(bus.alu_out), 64'(12));
        check("fwd add dataB", 64'(bus.dataB), 64'(7));
        check("fwd add stall", 64'(bus.ex_stall), 64'(0));

        // PC + immediate
        bus.ID_EX_pc      = W'(32'h100);
        bus.ID_EX_imm_out = W'(32'h20);
        bus.ID_EX_ASel    = 1'b1;
        bus.ID_EX_BSel    = 1'b1;
        settle();
        check("pc+imm alu_out", 64'(bus.alu_out), 64'(32'h120));
        check("pc+imm dataB", 64'(bus.dataB), 64'(7));

        // Randomized ALU / forwarding
        for (int i = 0; i < 24; i++) begin
            tick();
            randomize_bus();
            bus.ID_EX_valid = 1'($urandom_range(0, 1));
            bus.ID_EX_md_en = 1'b0;
            settle();
            ea = bus.ID_EX_ASel ? bus.ID_EX_pc
                 : fwd_pick(bus.forwardA, bus.ID_EX_data_out_1, bus.WB_data, bus.EX_MEM_alu_out);
            eb = fwd_pick(bus.forwardB, bus.ID_EX_data_out_2, bus.WB_data, bus.EX_MEM_alu_out);
            check($sformatf("rand alu %0d dataB", i), 64'(bus.dataB), 64'(eb));
            if (bus.ID_EX_BSel) eb = bus.ID_EX_imm_out;
            check($sformatf("rand alu %0d alu_out", i), 64'(bus.alu_out),
                  64'(alu_model(bus.ID_EX_alu_sel, ea, eb)));
            check($sformatf("rand alu %0d stall", i), 64'(bus.ex_stall), 64'(0));
        end

        // md_en without valid must not start
        bus.ID_EX_valid = 1'b0;
        bus.ID_EX_md_en = 1'b1;
        settle();
        check("invalid md no stall", 64'(bus.ex_stall), 64'(0));
        tick();

        // Flush in IDLE blocks acceptance
        bus.ID_EX_valid = 1'b1;
        bus.flush       = 1'b1;
        settle();
        check("idle flush no accept", 64'(bus.ex_stall), 64'(0));
        tick();
        bus.flush       = 1'b0;
        bus.ID_EX_md_en = 1'b0;
        settle();
        check("idle flush stays idle", 64'(bus.ex_stall), 64'(0));
        tick();

        // Directed mul/div, back to back
        run_md(MD_MUL,   W'(32'hFFFF_FFFF), W'(2), "mul max*2");
        run_md(MD_MULHU, W'(32'hFFFF_FFFF), W'(2), "mulhu max*2");
        run_md(MD_DIVU,  W'(100), W'(7), "divu 100/7");
        run_md(MD_REMU,  W'(100), W'(7), "remu 100/7");
        run_md(MD_DIVU,  W'(9), W'(0), "divu 9/0");
        run_md(MD_REMU,  W'(9), W'(0), "remu 9/0");

        // Randomized mul/div, back to back
        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = W'(0);
                1: rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            run_md(rop, ra, rb, $sformatf("rand md %0d", i));
        end

        // Flush at T+10, then MUL 3x4
        start_md(MD_MULHU, W'($urandom), W'($urandom));
        settle();
        check("flush op accept", 64'(bus.ex_stall), 64'(1));
        repeat (10) tick();
        bus.flush = 1'b1;
        settle();
        check("flush cycle stall", 64'(bus.ex_stall), 64'(0));
        check("flush cycle done", 64'(bus.md_done), 64'(0));
        tick();
        run_md(MD_MUL, W'(3), W'(4), "mul 3x4 after flush");

        // Reset at T+5
        start_md(MD_DIVU, W'($urandom), W'($urandom_range(1, 255)));
        settle();
        check("reset op accept", 64'(bus.ex_stall), 64'(1));
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset           = 1'b0;
        bus.ID_EX_md_en = 1'b0;
        settle();
        check("post reset stall", 64'(bus.ex_stall), 64'(0));
        check("post reset done", 64'(bus.md_done), 64'(0));
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.md_done) dones++;
            tick();
        end
        check("no stale done after reset", 64'(dones), 64'(0));
        run_md(MD_REMU, W'(1000), W'(37), "remu after reset");

        bus.ID_EX_md_en = 1'b0;
        settle();
        check("final done low", 64'(bus.md_done), 64'(0));
        check("final stall low", 64'(bus.ex_stall), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
